maxpool_tx_packer: RTL and testbench

Transmit-side companion to the max-pool accelerator's 32-bit packed input path. Accepts pooled result bytes one per handshake from the pooling datapath and packs four bytes per 32-bit word, with lane 0 in bits [31:24]. This is the same byte order the pool's input side uses to unpack words. Packed words are streamed out over a valid/ready interface with a last-word flag, so pooled frames return to the bus in the format the accelerator consumes.

---
 rtl/maxpool_tx_packer.sv | 157 +++++++++++++++
 tb/tb_maxpool_tx_packer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_tx_packer.sv
// rtl/maxpool_tx_packer.sv - packs pooled bytes four per 32-bit word (lane 0 in [31:24]) onto a valid/ready stream.
// Define MAXPOOL_TX_ROW_ALIGN_EN to start every output row in lane 0.
module maxpool_tx_packer #(
  parameter int BITS = 8,
  parameter int DIM  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     cfg_m,
  input  logic [31:0]     cfg_p,
  input  logic            pix_valid,
  input  logic [BITS-1:0] pix_data,
  output logic            pix_ready,
  output logic            word_valid,
  output logic [31:0]     word_data,
  output logic            word_last,
  input  logic            word_ready,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int HALF = DIM / 2;
  localparam int CW   = $clog2(HALF + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cols, rows, col, row;
  logic [1:0]    lane;
  logic [31:0]   asm_data;
  logic          asm_full, asm_last;
  logic [31:0]   out_data;
  logic          out_valid, out_last;

  logic [CW-1:0] cfg_c, cfg_r;
  logic          byte_acc, col_end, last_byte, close, out_free, fire;
  logic [31:0]   lane_byte, word_in;

  function automatic logic [CW-1:0] sat_half(input logic [31:0] v);
    logic [31:0] h;
    h = v >> 1;
    if (h > 32'(HALF)) return CW'(HALF);
    return h[CW-1:0];
  endfunction

  assign cfg_c = sat_half(cfg_m);
  assign cfg_r = sat_half(cfg_p);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = start && busy;
  assign pix_ready = (state == S_LOAD) && !asm_full;

  assign word_valid = out_valid;
  assign word_data  = out_data;
  assign word_last  = out_last;

  assign byte_acc  = pix_valid && pix_ready;
  assign col_end   = (col == cols - CW'(1));
  assign last_byte = byte_acc && col_end && (row == rows - CW'(1));
  assign out_free  = !out_valid || word_ready;
  assign fire      = out_valid && word_ready;

  assign lane_byte = {pix_data, {(32-BITS){1'b0}}} >> {lane, 3'b000};
  assign word_in   = asm_data | lane_byte;

`ifdef MAXPOOL_TX_ROW_ALIGN_EN
  assign close = byte_acc && ((lane == 2'd3) || col_end);
`else
  assign close = byte_acc && ((lane == 2'd3) || last_byte);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_c == '0 || cfg_r == '0) state_nxt = S_DONE;
          else                            state_nxt = S_LOAD;
        end
      end
      S_LOAD:  if (last_byte) state_nxt = S_DRAIN;
      S_DRAIN: if (fire && out_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols      <= '0;
      rows      <= '0;
      col       <= '0;
      row       <= '0;
      lane      <= '0;
      asm_data  <= '0;
      asm_full  <= 1'b0;
      asm_last  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cols     <= cfg_c;
        rows     <= cfg_r;
        col      <= '0;
        row      <= '0;
        lane     <= '0;
        asm_data <= '0;
      end

      // A freshly closed word bypasses the assembly hold when the output slot frees this cycle.
      if (close && out_free) begin
        out_data  <= word_in;
        out_valid <= 1'b1;
        out_last  <= last_byte;
      end else if (asm_full && out_free) begin
        out_data  <= asm_data;
        out_valid <= 1'b1;
        out_last  <= asm_last;
        asm_data  <= '0;
        asm_full  <= 1'b0;
        asm_last  <= 1'b0;
      end else if (fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (byte_acc) begin
        if (close) begin
          lane     <= '0;
          asm_data <= out_free ? 32'd0 : word_in;
          asm_full <= !out_free;
          asm_last <= !out_free && last_byte;
        end else begin
          lane     <= lane + 2'd1;
          asm_data <= word_in;
        end
        if (col_end) begin
          col <= '0;
          row <= last_byte ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_tx_packer.sv
// tb/tb_maxpool_tx_packer.sv - randomized self-checking bench for maxpool_tx_packer against a frame-level word model.
module tb_maxpool_tx_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_m = '0, cfg_p = '0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready = 1'b0;
  logic        busy, done, err;

  always #5 clk = ~clk;

  maxpool_tx_packer #(.BITS(8), .DIM(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_p(cfg_p),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .busy(busy), .done(done), .err(err)
  );

  int ncmp = 0, nfail = 0;
  int vprob = 100, rprob = 100;
  int acc_cnt = 0, cyc = 0, first_acc = -1, last_acc = -1;
  logic [7:0]  byte_q[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] log_q[$];
  logic        model_busy = 1'b0, exp_done_next = 1'b0, have_hold = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;
  logic        nd, nb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int sat(input logic [31:0] v);
    int h;
    h = int'(v >> 1);
    return (h > 16) ? 16 : h;
  endfunction

  // Expected word stream for a frame, built straight from the byte list.
  task automatic build_expected(input int c, input int r);
    logic [7:0]  b[$];
    logic [31:0] w;
    int n, nw, wpr;
    b = byte_q;
    n = c * r;
    exp_d.delete();
    exp_l.delete();
`ifdef MAXPOOL_TX_ROW_ALIGN_EN
    wpr = (c + 3) / 4;
    nw  = n;
    for (int rr = 0; rr < r; rr++)
      for (int wi = 0; wi < wpr; wi++) begin
        w = '0;
        for (int j = 0; j < 4; j++)
          if (4 * wi + j < c) w[31-8*j -: 8] = b[rr*c + 4*wi + j];
        exp_d.push_back(w);
        exp_l.push_back(rr == r - 1 && wi == wpr - 1);
      end
`else
    wpr = 0;
    nw  = (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * i + j < n) w[31-8*j -: 8] = b[4*i + j];
      exp_d.push_back(w);
      exp_l.push_back(i == nw - 1);
    end
`endif
  endtask

  // Byte source and downstream ready, both randomized.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (byte_q.size() > 0 && $urandom_range(0, 99) < vprob) begin
      pix_valid = 1'b1;
      pix_data  = byte_q[0];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 8'($urandom);
    end
    word_ready = ($urandom_range(0, 99) < rprob);
    #3;
    if (rst_n && pix_valid && pix_ready) begin
      void'(byte_q.pop_front());
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
  end

  // Single per-cycle compare process.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_busy    = 1'b0;
      exp_done_next = 1'b0;
      have_hold     = 1'b0;
    end else begin
      chk("done", done, exp_done_next);
      chk("busy", busy, model_busy);
      chk("err", err, start && model_busy);
      if (!model_busy) begin
        chk("idle_pix_ready", pix_ready, 0);
        chk("idle_word_valid", word_valid, 0);
      end
      if (have_hold) begin
        chk("hold_valid", word_valid, 1);
        chk("hold_data", word_data, hold_d);
        chk("hold_last", word_last, hold_l);
      end
      nd = 1'b0;
      if (word_valid && word_ready) begin
        if (exp_d.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL extra_word: got %h, expected no word at %0t", word_data, $time);
        end else begin
          chk("word_data", word_data, exp_d[0]);
          chk("word_last", word_last, exp_l[0]);
          nd = exp_l[0];
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
        end
        log_q.push_back(word_data);
      end
      have_hold = word_valid && !word_ready;
      hold_d    = word_data;
      hold_l    = word_last;
      nb = model_busy;
      if (start && !model_busy) begin
        nb = 1'b1;
        if (sat(cfg_m) == 0 || sat(cfg_p) == 0) nd = 1'b1;
      end
      if (exp_done_next) nb = 1'b0;
      model_busy    = nb;
      exp_done_next = nd;
    end
  end

  task automatic prep(input logic [31:0] m, input logic [31:0] p, input bit seq);
    int c, r;
    c = sat(m);
    r = sat(p);
    byte_q.delete();
    for (int i = 0; i < c * r; i++) byte_q.push_back(seq ? 8'(i + 1) : 8'($urandom));
    build_expected(c, r);
    log_q.delete();
    acc_cnt   = 0;
    first_acc = -1;
    @(posedge clk); #1;
    cfg_m = m;
    cfg_p = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 6000; k++) begin
      @(posedge clk); #2;
      if (!model_busy && !exp_done_next && exp_d.size() == 0 && byte_q.size() == 0) break;
    end
    chk("frame_completes", k < 6000, 1);
  endtask

  task automatic run_frame(input logic [31:0] m, input logic [31:0] p, input bit seq, input bit inject);
    prep(m, p, seq);
    if (inject) begin
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
      if (busy) begin
        cfg_m = $urandom;
        cfg_p = $urandom;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    wait_idle();
  endtask

  initial begin : main
    int k;
    bit seen, wv;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_data", word_data, 0);
    chk("rst_flags", {pix_ready, word_valid, word_last, busy, done, err}, 0);
    #1 rst_n = 1'b1;

    // 8x8 streaming frame, full rate.
    vprob = 100; rprob = 100;
    run_frame(8, 8, 1, 0);
    chk("t1_nwords", log_q.size(), 4);
    chk("t1_w0", log_q[0], 32'h01020304);
    chk("t1_w1", log_q[1], 32'h05060708);
    chk("t1_w2", log_q[2], 32'h090A0B0C);
    chk("t1_w3", log_q[3], 32'h0D0E0F10);
    chk("t1_no_bubble", last_acc - first_acc, 15);

    // 3x3 frame, padding depends on row alignment.
    run_frame(6, 6, 1, 0);
    chk("t2_nwords", log_q.size(), 3);
`ifdef MAXPOOL_TX_ROW_ALIGN_EN
    chk("t2_w0", log_q[0], 32'h01020300);
    chk("t2_w1", log_q[1], 32'h04050600);
    chk("t2_w2", log_q[2], 32'h07080900);
`else
    chk("t2_w0", log_q[0], 32'h01020304);
    chk("t2_w1", log_q[1], 32'h05060708);
    chk("t2_w2", log_q[2], 32'h09000000);
`endif

    // Downstream stall from the first word: packer fills its two slots then blocks.
    rprob = 0;
    prep(8, 8, 1);
    for (k = 0; k < 50; k++) begin
      if (word_valid) break;
      @(posedge clk); #1;
    end
    chk("t3_first_word_seen", k < 50, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("t3_stall_bytes", acc_cnt, 8);
    chk("t3_stall_pix_ready", pix_ready, 0);
    rprob = 100;
    wait_idle();
    chk("t3_nwords", log_q.size(), 4);
    chk("t3_w1", log_q[1], 32'h05060708);

    // start during LOAD.
    prep(8, 8, 1);
    repeat (3) @(posedge clk);
    #1;
    cfg_m = 32'd2; cfg_p = 32'd2;
    start = 1'b1;
    #2 chk("t4_err_pulse", err, 1);
    @(posedge clk); #1;
    start = 1'b0;
    #2 chk("t4_err_clear", err, 0);
    wait_idle();
    chk("t4_nwords", log_q.size(), 4);
    chk("t4_w3", log_q[3], 32'h0D0E0F10);

    // Degenerate frame: cfg_m=1 gives zero columns.
    prep(1, 8, 0);
    seen = 1'b0; wv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (done) seen = 1'b1;
      if (word_valid) wv = 1'b1;
      @(posedge clk); #1;
    end
    chk("t5_zero_done", seen, 1);
    chk("t5_zero_no_word", wv, 0);
    wait_idle();

    // start coinciding with done is rejected.
    prep(8, 8, 1);
    for (k = 0; k < 200; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    chk("t6_done_seen", k < 200, 1);
    cfg_m = 32'd8; cfg_p = 32'd8;
    start = 1'b1;
    #2 chk("t6_err_on_done", err, 1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("t6_stays_idle", busy, 0);

    // Asynchronous reset mid-frame, then a clean frame.
    prep(8, 8, 1);
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (acc_cnt >= 5) break;
    end
    rst_n = 1'b0;
    byte_q.delete();
    exp_d.delete();
    exp_l.delete();
    #1;
    chk("t7_rst_word_data", word_data, 0);
    chk("t7_rst_flags", {pix_ready, word_valid, word_last, busy, done, err}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_frame(8, 8, 1, 0);
    chk("t7_first_word", log_q[0], 32'h01020304);

    // Randomized frames with random handshakes and occasional stray starts.
    for (int it = 0; it < 25; it++) begin
      vprob = $urandom_range(40, 100);
      rprob = $urandom_range(40, 100);
      run_frame($urandom_range(0, 40), $urandom_range(0, 40), 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #3000000;
    nfail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $fatal(1);
  end

endmodule
